jtkcpu_alu_seq: RTL and testbench

// Multi-cycle sequencer in front of the KCPU ALU. Runs the iterated D-register ops (ASRD/LSRD/RORD/ROLD/ASLD by count).

---
 rtl/jtkcpu_alu_seq.sv | 158 +++++++++++++++
 tb/tb_jtkcpu_alu_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_alu_seq.sv
// -----------------------------------------------------------------------------
// jtkcpu_alu_seq
// Multi-cycle sequencer in front of the KCPU ALU. It iterates the D-register
// shift/rotate ops (ASRD/LSRD/RORD/ROLD/ASLD by count) and runs the divider
// handshake (DIV_X_B). It holds the running value and CC, feeds them back into
// the ALU once per cen, and reports completion with a one-cen-period done.
//
// Ports
//   clk, rst, cen        : clock, async active-high reset, clock enable
//   start, op, div, cnt  : request, opcode to iterate, divide flag, shift count
//   d_in, cc_in          : initial operand and CC
//   alu_op/opnd0/cc      : latched op, running value and running CC to the ALU
//   alu_rslt, alu_ccr    : ALU result and CC out
//   div_start, div_busy  : divider start strobe / divider running
//   busy, done, err      : not idle / finished (FIN) / divider timeout (sticky)
//   d_out, cc_out        : running/final value and CC
// -----------------------------------------------------------------------------
module jtkcpu_alu_seq #(
  parameter int CNTW    = 8,
  parameter int DIV_TMO = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            start,
  input  logic [7:0]      op,
  input  logic            div,
  input  logic [CNTW-1:0] cnt,
  input  logic [15:0]     d_in,
  input  logic [7:0]      cc_in,
  output logic [7:0]      alu_op,
  output logic [15:0]     alu_opnd0,
  output logic [7:0]      alu_cc,
  input  logic [15:0]     alu_rslt,
  input  logic [7:0]      alu_ccr,
  output logic            div_start,
  input  logic            div_busy,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [15:0]     d_out,
  output logic [7:0]      cc_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_DIV_GO,
    S_DIV_WAIT,
    S_FIN
  } state_t;

  // Wide enough to hold DIV_TMO-1 even for DIV_TMO == 1.
  localparam int              TMOW     = $clog2(DIV_TMO + 1);
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(DIV_TMO - 1);

  state_t          state_q, state_d;
  logic [7:0]      op_q,    op_d;
  logic [15:0]     acc_q,   acc_d;
  logic [7:0]      ccr_q,   ccr_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic [TMOW-1:0] tmo_q,   tmo_d;
  logic            err_q,   err_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      ccr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else if (cen) begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      ccr_q   <= ccr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    ccr_d   = ccr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          acc_d = d_in;
          ccr_d = cc_in;
          cnt_d = cnt;
          err_d = 1'b0;
          // A divide request wins over any shift count supplied with it.
          if (div)              state_d = S_DIV_GO;
          else if (cnt == '0)   state_d = S_FIN;
          else                  state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        acc_d = alu_rslt;
        ccr_d = alu_ccr;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = S_FIN;
      end

      S_DIV_GO: begin
        tmo_d   = '0;
        state_d = S_DIV_WAIT;
      end

      S_DIV_WAIT: begin
        if (!div_busy) begin
          acc_d   = alu_rslt;
          ccr_d   = alu_ccr;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + TMOW'(1);
          // Abort leaves the operand and CC as they were before the divide.
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign alu_op    = op_q;
  assign alu_opnd0 = acc_q;
  assign alu_cc    = ccr_q;
  assign d_out     = acc_q;
  assign cc_out    = ccr_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  // Decoded from state so the strobe lasts the whole cen period, even when
  // cen is held low.
  assign div_start = (state_q == S_DIV_GO);

endmodule

// File: tb/tb_jtkcpu_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_jtkcpu_alu_seq
// Directed bench for jtkcpu_alu_seq. A small behavioural ALU (LSRD, ROLD
// through C, and a divider stub) closes the loop. Each accepted request pushes
// its expected value, CC, err and completion edge into a scoreboard; a monitor
// pops and compares on every rising edge of done.
// -----------------------------------------------------------------------------
module tb_jtkcpu_alu_seq;

  localparam logic [7:0] LSRD_IMM = 8'h44;
  localparam logic [7:0] ROLD_IMM = 8'h49;
  localparam logic [7:0] DIV_X_B  = 8'h8E;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [7:0]  cc;
    logic        err;
    int          at_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  op = '0;
  logic        div = 1'b0;
  logic [7:0]  cnt = '0;
  logic [15:0] d_in = '0;
  logic [7:0]  cc_in = '0;
  logic [7:0]  alu_op;
  logic [15:0] alu_opnd0;
  logic [7:0]  alu_cc;
  logic [15:0] alu_rslt;
  logic [7:0]  alu_ccr;
  logic        div_start;
  logic        div_busy;
  logic        busy, done, err;
  logic [15:0] d_out;
  logic [7:0]  cc_out;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;        // cen edges seen since time zero
  int   cen_rate = 1;    // cen high on 1 of every cen_rate clocks
  int   cen_ph = 0;
  int   stub_len = 5;    // divider busy length in cen edges
  bit   stub_hang = 1'b0;
  int   busy_left = 0;
  int   ds_edges = 0;    // cen edges with div_start high

  jtkcpu_alu_seq #(.CNTW(8), .DIV_TMO(32)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .op(op), .div(div),
    .cnt(cnt), .d_in(d_in), .cc_in(cc_in), .alu_op(alu_op),
    .alu_opnd0(alu_opnd0), .alu_cc(alu_cc), .alu_rslt(alu_rslt),
    .alu_ccr(alu_ccr), .div_start(div_start), .div_busy(div_busy),
    .busy(busy), .done(done), .err(err), .d_out(d_out), .cc_out(cc_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cen_ph = (cen_ph + 1) % cen_rate;
    cen    = (cen_ph == 0);
  end

  always @(posedge clk) if (cen) ecnt <= ecnt + 1;

  // Behavioural ALU: C is CC bit 0, other CC bits pass through.
  always_comb begin
    alu_rslt = alu_opnd0;
    alu_ccr  = alu_cc;
    case (alu_op)
      LSRD_IMM: begin
        alu_rslt = {1'b0, alu_opnd0[15:1]};
        alu_ccr  = {alu_cc[7:1], alu_opnd0[0]};
      end
      ROLD_IMM: begin
        alu_rslt = {alu_opnd0[14:0], alu_cc[0]};
        alu_ccr  = {alu_cc[7:1], alu_opnd0[15]};
      end
      DIV_X_B: begin
        alu_rslt = div_busy ? 16'hDEAD : 16'h0302;
        alu_ccr  = 8'h20;
      end
      default: ;
    endcase
  end

  // Divider stub: starts on a div_start cen edge, counts down unless hung.
  always @(posedge clk) begin
    if (cen) begin
      if (div_start) begin
        busy_left <= stub_len;
        ds_edges  <= ds_edges + 1;
      end else if (busy_left != 0 && !stub_hang) begin
        busy_left <= busy_left - 1;
      end
    end
  end
  assign div_busy = (busy_left != 0);

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_monitor();
    logic done_prev = 1'b0;
    exp_t it;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          it = sb.pop_front();
          check({it.name, "_d"},    32'(d_out),  32'(it.d));
          check({it.name, "_cc"},   32'(cc_out), 32'(it.cc));
          check({it.name, "_err"},  32'(err),    32'(it.err));
          check({it.name, "_edge"}, 32'(ecnt),   32'(it.at_edge));
        end
      end
      done_prev = done;
    end
  endtask

  task automatic wait_idle(input string nm, input int max_clk);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max_clk);
    check({nm, "_idle"}, 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  // Drive one request, push its expectation at the accept edge, wait for idle.
  task automatic issue(input string nm, input logic [7:0] op_i,
                       input logic div_i, input logic [7:0] cnt_i,
                       input logic [15:0] d_i, input logic [7:0] cc_i,
                       input int lat, input logic [15:0] exp_d,
                       input logic [7:0] exp_cc, input logic exp_err);
    exp_t it;
    int   g = 0;
    @(negedge clk);
    op = op_i; div = div_i; cnt = cnt_i; d_in = d_i; cc_in = cc_i;
    start = 1'b1;
    do begin
      @(posedge clk);
      g++;
    end while (!cen && g < 10);
    #1;
    it.name = nm; it.d = exp_d; it.cc = exp_cc; it.err = exp_err;
    it.at_edge = ecnt + lat - 1;
    sb.push_back(it);
    @(negedge clk);
    start = 1'b0;
    wait_idle(nm, 400);
  endtask

  initial begin
    int   ds0;
    exp_t it;
    fork
      run_monitor();
    join_none

    // Reset state
    #12;
    check("rst_d_out",  32'(d_out),     32'(0));
    check("rst_cc_out", 32'(cc_out),    32'(0));
    check("rst_alu_op", 32'(alu_op),    32'(0));
    check("rst_busy",   32'(busy),      32'(0));
    check("rst_done",   32'(done),      32'(0));
    check("rst_err",    32'(err),       32'(0));
    check("rst_divst",  32'(div_start), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // name, op, div, cnt, d_in, cc_in, latency, exp d, exp cc, exp err
    issue("cnt0",  LSRD_IMM, 1'b0, 8'd0,  16'h1234, 8'h05, 1,  16'h1234, 8'h05, 1'b0);
    issue("lsrd3", LSRD_IMM, 1'b0, 8'd3,  16'h8001, 8'h00, 4,  16'h1000, 8'h00, 1'b0);
    issue("rold17",ROLD_IMM, 1'b0, 8'd17, 16'h0001, 8'h00, 18, 16'h0001, 8'h00, 1'b0);

    cen_rate = 3;
    issue("slow_lsrd4", LSRD_IMM, 1'b0, 8'd4, 16'hFFFF, 8'h00, 5, 16'h0FFF, 8'h01, 1'b0);
    cen_rate = 1;
    repeat (3) @(negedge clk);

    // Divide: 5 busy edges then result; cnt must be ignored.
    ds0 = ds_edges;
    issue("div", DIV_X_B, 1'b1, 8'd9, 16'h0A0B, 8'h0F, 8, 16'h0302, 8'h20, 1'b0);
    check("div_start_edges", 32'(ds_edges - ds0), 32'(1));

    // Divide with a hung divider: timeout after 32 DIV_WAIT edges.
    stub_len  = 1;
    stub_hang = 1'b1;
    ds0 = ds_edges;
    issue("div_tmo", DIV_X_B, 1'b1, 8'd0, 16'h5555, 8'h0F, 34, 16'h5555, 8'h0F, 1'b1);
    check("tmo_start_edges", 32'(ds_edges - ds0), 32'(1));
    check("err_held", 32'(err), 32'(1));
    stub_hang = 1'b0;
    stub_len  = 5;
    repeat (2) @(negedge clk);

    // start held high through FIN: second accept only from IDLE, two edges on.
    op = LSRD_IMM; div = 1'b0; cnt = 8'd0; d_in = 16'h00C3; cc_in = 8'h02;
    start = 1'b1;
    @(posedge clk);
    #1;
    it.name = "hold1"; it.d = 16'h00C3; it.cc = 8'h02; it.err = 1'b0;
    it.at_edge = ecnt;
    sb.push_back(it);
    @(posedge clk);
    @(posedge clk);
    #1;
    it.name = "hold2"; it.at_edge = ecnt;
    sb.push_back(it);
    @(negedge clk);
    start = 1'b0;
    wait_idle("hold", 50);

    // Reset in the middle of a 10-step shift: no done, outputs cleared at once.
    op = LSRD_IMM; div = 1'b0; cnt = 8'd10; d_in = 16'h8001; cc_in = 8'h00;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_d_out",  32'(d_out),  32'(0));
    check("mid_rst_cc_out", 32'(cc_out), 32'(0));
    check("mid_rst_alu_op", 32'(alu_op), 32'(0));
    check("mid_rst_busy",   32'(busy),   32'(0));
    check("mid_rst_done",   32'(done),   32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    issue("retry_lsrd3", LSRD_IMM, 1'b0, 8'd3, 16'h8001, 8'h00, 4, 16'h1000, 8'h00, 1'b0);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
